// File: rtl/foodfight_bus_pkg.sv
// Shared types and defaults for the 68000 bus cycle controller.
package foodfight_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_VPA_SYNC,
        ST_VPA_XFER,
        ST_HOLD,
        ST_BERR
    } bus_state_t;

    localparam int WAIT_STATES_DEF = 0;
    localparam int E_DIV_DEF       = 10;
    localparam int E_HIGH_DEF      = 4;
    localparam int BERR_CYCLES_DEF = 64;

    // Wide enough for the E counter, the wait counter and the watchdog (max 255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/bus_cycle_ctl_if.sv
// CPU-side bus handshake bundle; master is the CPU/decoder, slave is the controller.
interface bus_cycle_ctl_if;
    logic as_n;
    logic sel_dtack;
    logic sel_vpa;
    logic sel_avec;
    logic dtack_n;
    logic vpa_n;
    logic vma_n;
    logic e_clk;
    logic periph_stb;
    logic berr_n;

    modport master (
        output as_n, sel_dtack, sel_vpa, sel_avec,
        input  dtack_n, vpa_n, vma_n, e_clk, periph_stb, berr_n
    );

    modport slave (
        input  as_n, sel_dtack, sel_vpa, sel_avec,
        output dtack_n, vpa_n, vma_n, e_clk, periph_stb, berr_n
    );
endinterface

// File: rtl/e_clk_gen.sv
// Free-running 6800 E clock: counter 0..E_DIV-1, high for the last E_HIGH counts.
module e_clk_gen
    import foodfight_bus_pkg::*;
#(
    parameter int E_DIV  = E_DIV_DEF,
    parameter int E_HIGH = E_HIGH_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic e_clk,
    output logic wrap
);

    logic [CNT_W-1:0] cnt_reg;

    // wrap is high while the next edge returns the counter to 0 (E falling edge).
    assign wrap  = (cnt_reg == CNT_W'(E_DIV - 1));
    assign e_clk = (cnt_reg >= CNT_W'(E_DIV - E_HIGH));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (wrap) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bus_cycle_ctl.sv
// 68000 bus cycle controller: DTACK, VPA/AVEC (E-synchronous) and unclaimed cycles.
// Define BERR_TIMEOUT_EN to build the bus-error watchdog; otherwise berr_n is tied high.
module bus_cycle_ctl
    import foodfight_bus_pkg::*;
#(
    parameter int WAIT_STATES = WAIT_STATES_DEF,
    parameter int E_DIV       = E_DIV_DEF,
    parameter int E_HIGH      = E_HIGH_DEF,
    parameter int BERR_CYCLES = BERR_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    bus_cycle_ctl_if.slave bus
);

    logic e_clk_w;
    logic e_wrap;

    e_clk_gen #(
        .E_DIV (E_DIV),
        .E_HIGH(E_HIGH)
    ) u_e_clk_gen (
        .clk  (clk),
        .reset(reset),
        .e_clk(e_clk_w),
        .wrap (e_wrap)
    );

    bus_state_t       state_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             armed_reg;
    logic             dtack_n_reg;
    logic             vpa_n_reg;
    logic             vma_n_reg;
    logic             stb_reg;
`ifdef BERR_TIMEOUT_EN
    logic [CNT_W-1:0] wd_cnt_reg;
    logic             unclaimed_reg;
    logic             berr_n_reg;
    logic             wd_expired;

    assign wd_expired = (wd_cnt_reg == CNT_W'(BERR_CYCLES - 1));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= '0;
            armed_reg     <= 1'b0;
            dtack_n_reg   <= 1'b1;
            vpa_n_reg     <= 1'b1;
            vma_n_reg     <= 1'b1;
            stb_reg       <= 1'b0;
`ifdef BERR_TIMEOUT_EN
            wd_cnt_reg    <= '0;
            unclaimed_reg <= 1'b0;
            berr_n_reg    <= 1'b1;
`endif
        end else begin
            stb_reg <= 1'b0;
            if (bus.as_n && state_reg != ST_IDLE) begin
                // Strobe released: end or abort the cycle from any active state.
                state_reg   <= ST_IDLE;
                dtack_n_reg <= 1'b1;
                vpa_n_reg   <= 1'b1;
                vma_n_reg   <= 1'b1;
`ifdef BERR_TIMEOUT_EN
                berr_n_reg  <= 1'b1;
`endif
            end else begin
`ifdef BERR_TIMEOUT_EN
                wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
`endif
                unique case (state_reg)
                    ST_IDLE: begin
                        if (bus.as_n) begin
                            armed_reg <= 1'b1;
                        end else if (armed_reg) begin
                            // A new cycle only starts after as_n was seen high in IDLE.
                            armed_reg <= 1'b0;
`ifdef BERR_TIMEOUT_EN
                            wd_cnt_reg    <= '0;
                            unclaimed_reg <= 1'b0;
`endif
                            if (bus.sel_avec || bus.sel_vpa) begin
                                state_reg <= ST_VPA_SYNC;
                            end else if (bus.sel_dtack) begin
                                state_reg    <= ST_WAIT;
                                wait_cnt_reg <= CNT_W'(WAIT_STATES);
                            end else begin
                                state_reg <= ST_HOLD;
`ifdef BERR_TIMEOUT_EN
                                unclaimed_reg <= 1'b1;
`endif
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (wait_cnt_reg == '0) begin
                            state_reg   <= ST_ACK;
                            dtack_n_reg <= 1'b0;
`ifdef BERR_TIMEOUT_EN
                        end else if (wd_expired) begin
                            state_reg  <= ST_BERR;
                            berr_n_reg <= 1'b0;
`endif
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg - CNT_W'(1);
                        end
                    end
                    ST_VPA_SYNC: begin
                        vpa_n_reg <= 1'b0;
                        if (e_wrap) begin
                            state_reg <= ST_VPA_XFER;
                            vma_n_reg <= 1'b0;
`ifdef BERR_TIMEOUT_EN
                        end else if (wd_expired) begin
                            state_reg  <= ST_BERR;
                            vpa_n_reg  <= 1'b1;
                            berr_n_reg <= 1'b0;
`endif
                        end
                    end
                    ST_VPA_XFER: begin
                        if (e_wrap) begin
                            state_reg <= ST_HOLD;
                            stb_reg   <= 1'b1;
                        end
                    end
                    ST_HOLD: begin
`ifdef BERR_TIMEOUT_EN
                        if (unclaimed_reg && wd_expired) begin
                            state_reg  <= ST_BERR;
                            berr_n_reg <= 1'b0;
                        end
`endif
                    end
                    ST_ACK, ST_BERR: begin
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.dtack_n    = dtack_n_reg;
    assign bus.vpa_n      = vpa_n_reg;
    assign bus.vma_n      = vma_n_reg;
    assign bus.periph_stb = stb_reg;
    assign bus.e_clk      = e_clk_w;
`ifdef BERR_TIMEOUT_EN
    assign bus.berr_n     = berr_n_reg;
`else
    assign bus.berr_n     = 1'b1;
`endif

endmodule
